// File: rtl/approx_dot_accum_pkg.sv
// Shared defaults, width helpers and FSM state type for the approximate dot-product accumulator.
// The mod-Q stage is present only when APPROX_DOT_MODQ_EN is defined.
package approx_mul_pkg;

    localparam int SZ_DEFAULT  = 8;
    localparam int LEN_DEFAULT = 16;
    localparam int Q_DEFAULT   = 3329;

    // Ceiling log2; returns 0 for an argument of 1.
    function automatic int clog2(input int value);
        int bits;
        int rest;
        bits = 0;
        rest = value - 1;
        while (rest > 0) begin
            bits = bits + 1;
            rest = rest >> 1;
        end
        return bits;
    endfunction

    // Accumulator width that can never overflow for len full-scale products.
    function automatic int accWidth(input int sz, input int len);
        return 2 * sz + clog2(len);
    endfunction

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        REDUCE = 2'd1,
        OUTPUT = 2'd2
    } dotState_t;

endpackage

// File: rtl/approx_dot_accum_reduce.sv
// Sequential restoring mod-Q reducer: one conditional subtract of Q<<k per cycle, k = ACCW-1..0.
// Used by approx_dot_accum only when APPROX_DOT_MODQ_EN is defined.
module mod_reduce_seq
    import approx_mul_pkg::*;
#(
    parameter int ACCW = 20,
    parameter int Q    = Q_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [ACCW-1:0] din,
    output logic            done,
    output logic [ACCW-1:0] dout
);

    localparam int KW = (clog2(ACCW) < 1) ? 1 : clog2(ACCW);
    localparam logic [2*ACCW-1:0] QWIDE = (2*ACCW)'(Q);

    logic [ACCW-1:0]   rem;
    logic [KW-1:0]     k;
    logic              running;
    logic [2*ACCW-1:0] qShift;
    logic [ACCW-1:0]   remStep;

    // The compare is done at double width so Q<<k never loses its top bits.
    always_comb begin
        qShift  = QWIDE << k;
        remStep = rem;
        if ({{ACCW{1'b0}}, rem} >= qShift) begin
            remStep = rem - qShift[ACCW-1:0];
        end
    end

    assign done = running && (k == '0);
    assign dout = remStep;

    always_ff @(posedge clk) begin
        if (rst) begin
            rem     <= '0;
            k       <= '0;
            running <= 1'b0;
        end else if (start) begin
            rem     <= din;
            k       <= KW'(ACCW - 1);
            running <= 1'b1;
        end else if (running) begin
            rem <= remStep;
            if (k == '0) begin
                running <= 1'b0;
            end else begin
                k <= k - 1'b1;
            end
        end
    end

endmodule

// File: rtl/approx_dot_accum.sv
// Accumulates LEN approximate products per dot product behind a valid/ready handshake.
// Define APPROX_DOT_MODQ_EN to reduce each result mod Q before it is presented.
module approx_dot_accum
    import approx_mul_pkg::*;
#(
    parameter int SZ  = SZ_DEFAULT,
    parameter int LEN = LEN_DEFAULT,
    parameter int Q   = Q_DEFAULT,
    localparam int ACCW = accWidth(SZ, LEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*SZ-1:0] in_prod,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [ACCW-1:0] out_sum,
    output logic            busy
);

    localparam int CNTW = clog2(LEN + 1);

    // Reject parameter sets the accumulator and reducer are not sized for.
    if (LEN < 1 || LEN > 256 || Q < 2 || Q > (2 ** (2 * SZ)) - 1) begin : gBadParams
        $error("approx_dot_accum: illegal LEN or Q");
    end

    dotState_t       state;
    dotState_t       stateNext;
    logic [ACCW-1:0] acc;
    logic [ACCW-1:0] accSum;
    logic [ACCW-1:0] sumReg;
    logic [CNTW-1:0] cnt;
    logic            accept;
    logic            lastAccept;
    logic            handshake;

    assign in_ready   = (state == ACCUM);
    assign out_valid  = (state == OUTPUT);
    assign busy       = (state != ACCUM) || (cnt != '0);
    assign out_sum    = sumReg;
    assign accept     = in_valid && in_ready;
    assign lastAccept = accept && (cnt == CNTW'(LEN - 1));
    assign handshake  = out_valid && out_ready;
    assign accSum     = acc + ACCW'(in_prod);

`ifdef APPROX_DOT_MODQ_EN
    logic            reduceDone;
    logic [ACCW-1:0] reduceOut;

    mod_reduce_seq #(
        .ACCW(ACCW),
        .Q   (Q)
    ) uReduce (
        .clk  (clk),
        .rst  (rst),
        .start(lastAccept),
        .din  (accSum),
        .done (reduceDone),
        .dout (reduceOut)
    );
`endif

    always_comb begin
        stateNext = state;
        case (state)
            ACCUM: begin
                if (lastAccept) begin
`ifdef APPROX_DOT_MODQ_EN
                    stateNext = REDUCE;
`else
                    stateNext = OUTPUT;
`endif
                end
            end
`ifdef APPROX_DOT_MODQ_EN
            REDUCE: begin
                if (reduceDone) begin
                    stateNext = OUTPUT;
                end
            end
`endif
            OUTPUT: begin
                if (out_ready) begin
                    stateNext = ACCUM;
                end
            end
            default: stateNext = ACCUM;
        endcase
    end

    // The result is captured into its own register so out_sum stays put through backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ACCUM;
            acc    <= '0;
            cnt    <= '0;
            sumReg <= '0;
        end else begin
            state <= stateNext;
            if (handshake) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= accSum;
                cnt <= cnt + 1'b1;
            end
`ifdef APPROX_DOT_MODQ_EN
            if (reduceDone) begin
                sumReg <= reduceOut;
            end
`else
            if (lastAccept) begin
                sumReg <= accSum;
            end
`endif
        end
    end

endmodule

// File: tb/tb_approx_dot_accum.sv
// Randomized self-checking bench for approx_dot_accum with LEN = 4, 16 and 1 instances side by side.
// Expected results come from a running-sum model, reduced mod Q when APPROX_DOT_MODQ_EN is defined.
module tb_approx_dot_accum;

`ifdef APPROX_DOT_MODQ_EN
    localparam bit MODQ = 1'b1;
`else
    localparam bit MODQ = 1'b0;
`endif
    localparam longint QMOD = 3329;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid  [3];
    logic [15:0] inProd   [3];
    logic        inReady  [3];
    logic        outValid [3];
    logic        outReady [3];
    logic        busy     [3];
    logic [17:0] sum0;
    logic [19:0] sum1;
    logic [15:0] sum2;

    int     lenOf  [3] = '{4, 16, 1};
    int     accwOf [3] = '{18, 20, 16};
    longint modelSum [3];
    int     monCnt   [3];
    int     total = 0;
    int     bad   = 0;

    always #5 clk = ~clk;

    approx_dot_accum #(.SZ(8), .LEN(4), .Q(3329)) dut0 (
        .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]), .in_prod(inProd[0]),
        .out_valid(outValid[0]), .out_ready(outReady[0]), .out_sum(sum0), .busy(busy[0])
    );
    approx_dot_accum #(.SZ(8), .LEN(16), .Q(3329)) dut1 (
        .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]), .in_prod(inProd[1]),
        .out_valid(outValid[1]), .out_ready(outReady[1]), .out_sum(sum1), .busy(busy[1])
    );
    approx_dot_accum #(.SZ(8), .LEN(1), .Q(3329)) dut2 (
        .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]), .in_prod(inProd[2]),
        .out_valid(outValid[2]), .out_ready(outReady[2]), .out_sum(sum2), .busy(busy[2])
    );

    // Count real accepts per instance; a completed handshake or a reset starts a fresh count.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                monCnt[d] <= 0;
            end else if (outValid[d] && outReady[d]) begin
                monCnt[d] <= 0;
            end else if (inValid[d] && inReady[d]) begin
                monCnt[d] <= monCnt[d] + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] getSum(input int d);
        case (d)
            0:       return {46'd0, sum0};
            1:       return {44'd0, sum1};
            default: return {48'd0, sum2};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got=%0d want=%0d", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [15:0] p, input int gap);
        int guard;
        repeat (gap) begin
            inValid[d] = 1'b0;
            inProd[d]  = 16'($urandom);
            @(negedge clk);
        end
        inValid[d] = 1'b1;
        inProd[d]  = p;
        guard = 0;
        while (!inReady[d] && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("readyBeforeAccept", inReady[d], 1);
        checkOutput("noEarlyValid", outValid[d], 0);
        @(posedge clk);
        modelSum[d] += longint'(p);
        @(negedge clk);
        inValid[d] = 1'b0;
    endtask

    task automatic finishDot(input int d, input int hold);
        longint want;
        int lat;
        logic [15:0] junk;
        want = MODQ ? (modelSum[d] % QMOD) : modelSum[d];
        lat = 1;
        while (!outValid[d] && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("latency", lat, MODQ ? accwOf[d] + 1 : 1);
        checkOutput("acceptCount", monCnt[d], lenOf[d]);
        checkOutput("sum", getSum(d), want);
        outReady[d] = 1'b0;
        for (int i = 0; i < hold; i++) begin
            junk = 16'($urandom);
            inValid[d] = junk[0];
            inProd[d]  = junk;
            @(negedge clk);
            checkOutput("holdSum", getSum(d), want);
            checkOutput("holdInReady", inReady[d], 0);
            checkOutput("holdValid", outValid[d], 1);
        end
        inValid[d]  = 1'b0;
        outReady[d] = 1'b1;
        @(negedge clk);
        outReady[d] = 1'b0;
        checkOutput("postInReady", inReady[d], 1);
        checkOutput("postValid", outValid[d], 0);
        checkOutput("postBusy", busy[d], 0);
        modelSum[d] = 0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) modelSum[d] = 0;
    endtask

    task automatic checkResetState(input int d);
        checkOutput("rstInReady", inReady[d], 1);
        checkOutput("rstValid", outValid[d], 0);
        checkOutput("rstBusy", busy[d], 0);
        checkOutput("rstSum", getSum(d), 0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            inValid[d]  = 1'b0;
            inProd[d]   = '0;
            outReady[d] = 1'b0;
            modelSum[d] = 0;
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 3; d++) checkResetState(d);

        // Back-to-back small products.
        applyStimulus(0, 16'd100, 0);
        applyStimulus(0, 16'd200, 0);
        applyStimulus(0, 16'd300, 0);
        applyStimulus(0, 16'd400, 0);
        finishDot(0, 0);

        // Full-scale 255*255 products, then five cycles of backpressure.
        repeat (4) applyStimulus(0, 16'd65025, 0);
        finishDot(0, 5);

        // Sixteen ones with random bubbles.
        repeat (16) applyStimulus(1, 16'd1, $urandom_range(3, 0));
        finishDot(1, 1);

        // Partial sum thrown away by a reset.
        applyStimulus(0, 16'd500, 0);
        applyStimulus(0, 16'd600, 0);
        pulseReset();
        checkResetState(0);
        repeat (4) applyStimulus(0, 16'd2, 0);
        finishDot(0, 2);

        // Reset one cycle after the final accept (inside REDUCE or OUTPUT).
        repeat (4) applyStimulus(0, 16'(($urandom_range(65535, 1))), 0);
        pulseReset();
        checkResetState(0);
        repeat (4) applyStimulus(0, 16'd7, 1);
        finishDot(0, 0);

        // Zero products and a single product equal to Q.
        repeat (16) applyStimulus(1, 16'd0, 0);
        finishDot(1, 0);
        applyStimulus(2, 16'd3329, 0);
        finishDot(2, 1);
        applyStimulus(2, 16'd65535, 0);
        finishDot(2, 0);

        // Randomized dot products on every instance.
        for (int t = 0; t < 6; t++) begin
            for (int d = 0; d < 3; d++) begin
                repeat (lenOf[d]) applyStimulus(d, 16'($urandom), $urandom_range(2, 0));
                finishDot(d, $urandom_range(3, 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
